// File: rtl/fpu_to_int_if.sv
// Valid/ready bundle for the FPU-word to integer converter.
// slave is the converter side, master the producer/consumer side.
interface fpu_to_int_if #(
    parameter int INT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [INT_W-1:0] float_in;
    logic             out_valid;
    logic             out_ready;
    logic [INT_W-1:0] int_out;
    logic [3:0]       flags_out;

    modport slave (
        input  in_valid, float_in, out_ready,
        output in_ready, out_valid, int_out, flags_out
    );

    modport master (
        output in_valid, float_in, out_ready,
        input  in_ready, out_valid, int_out, flags_out
    );
endinterface

// File: rtl/fpu_to_int.sv
// FPU-format word to signed integer, truncating toward zero.
// One shifter bit per cycle; flags are {invalid, overflow, inexact, zero}.
module fpu_to_int #(
    parameter int EXP_W = 9,
    parameter int MAN_W = 22,
    parameter int BIAS  = 255,
    parameter int INT_W = 32
) (
    input  logic           clock,
    input  logic           reset,
    fpu_to_int_if.slave    bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] SIGN  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(BIAS);
    localparam logic [EXP_W-1:0] EXP_PIV = EXP_W'(BIAS + MAN_W);
    localparam logic [EXP_W-1:0] EXP_K30 = EXP_W'(BIAS + INT_W - 2);
    localparam logic [EXP_W-1:0] EXP_K31 = EXP_W'(BIAS + INT_W - 1);
    localparam logic [4:0]       PIV_LO  = 5'(BIAS + MAN_W);

    logic [1:0]       state;
    logic [INT_W-1:0] sig;
    logic [4:0]       cnt;
    logic             right;
    logic             neg;
    logic             sticky;
    logic [INT_W-1:0] int_q;
    logic [3:0]       flags_q;

    logic             sgn;
    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man;
    logic [INT_W-1:0] sat;

    assign sgn   = bus.float_in[INT_W-1];
    assign exp_f = bus.float_in[INT_W-2 -: EXP_W];
    assign man   = bus.float_in[MAN_W-1:0];
    assign sat   = {sgn, {(INT_W-1){~sgn}}};

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.int_out   = int_q;
    assign bus.flags_out = flags_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            sig     <= '0;
            cnt     <= '0;
            right   <= 1'b0;
            neg     <= 1'b0;
            sticky  <= 1'b0;
            int_q   <= '0;
            flags_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        neg    <= sgn;
                        sticky <= 1'b0;
                        state  <= DONE;
                        // Earlier arms shadow later ones, so order matters.
                        priority case (1'b1)
                            (exp_f == '0): begin
                                int_q   <= '0;
                                flags_q <= 4'b0001;
                            end
                            (exp_f == EXP_MAX && man != '0): begin
                                int_q   <= '0;
                                flags_q <= 4'b1001;
                            end
                            (exp_f == EXP_MAX): begin
                                int_q   <= sat;
                                flags_q <= 4'b0100;
                            end
                            (exp_f < EXP_ONE): begin
                                int_q   <= '0;
                                flags_q <= 4'b0011;
                            end
                            (exp_f == EXP_K31 && sgn && man == '0): begin
                                int_q   <= sat;
                                flags_q <= 4'b0000;
                            end
                            (exp_f > EXP_K30): begin
                                int_q   <= sat;
                                flags_q <= 4'b0100;
                            end
                            default: begin
                                sig   <= {{(INT_W-MAN_W-1){1'b0}}, 1'b1, man};
                                right <= (exp_f < EXP_PIV);
                                cnt   <= (exp_f < EXP_PIV)
                                         ? (PIV_LO - exp_f[4:0])
                                         : (exp_f[4:0] - PIV_LO);
                                state <= SHIFT;
                            end
                        endcase
                    end
                end
                SHIFT: begin
                    if (cnt == '0) begin
                        state <= SIGN;
                    end else begin
                        cnt <= cnt - 5'd1;
                        if (right) begin
                            sig    <= sig >> 1;
                            sticky <= sticky | sig[0];
                        end else begin
                            sig <= sig << 1;
                        end
                    end
                end
                SIGN: begin
                    int_q   <= neg ? (~sig + 1'b1) : sig;
                    flags_q <= {2'b00, sticky, 1'b0};
                    state   <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_to_int.sv
// Directed-vector bench for fpu_to_int.
// Latency counts rising edges from the accept edge (inclusive) to out_valid.
module tb_fpu_to_int;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    fpu_to_int_if #(.INT_W(32)) bus ();

    fpu_to_int dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] f);
        int n = 0;
        bus.float_in = f;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 60) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 60) check("in_ready_wait", 32'(bus.in_ready), 32'd1);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic result(input string tag,
                          input logic [31:0] exp_int,
                          input logic [3:0]  exp_flags,
                          input int          exp_lat);
        int lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_int"}, bus.int_out, exp_int);
        check({tag, "_flags"}, 32'(bus.flags_out), 32'(exp_flags));
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic conv(input string tag, input logic [31:0] f,
                        input logic [31:0] ei, input logic [3:0] ef,
                        input int el);
        send(f);
        result(tag, ei, ef, el);
        take();
    endtask

    localparam logic [31:0] F_1P25 = {1'b0, 9'd255, 22'h100000};
    localparam logic [31:0] F_M6   = {1'b1, 9'd257, 22'h200000};
    localparam logic [31:0] F_2P22 = {1'b0, 9'd277, 22'h000000};

    initial begin
        bus.in_valid  = 1'b0;
        bus.float_in  = '0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_int", bus.int_out, 32'd0);
        check("rst_flags", 32'(bus.flags_out), 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        conv("p1p25", F_1P25, 32'h00000001, 4'b0010, 25);
        conv("m6", F_M6, 32'hFFFFFFFA, 4'b0000, 23);
        conv("p2p22", F_2P22, 32'h00400000, 4'b0000, 3);

        conv("denorm", {1'b0, 9'd0, 22'h012345}, 32'h0, 4'b0001, 1);
        conv("tiny", {1'b0, 9'd252, 22'h000001}, 32'h0, 4'b0011, 1);
        conv("inf", {1'b0, 9'd511, 22'h0}, 32'h7FFFFFFF, 4'b0100, 1);
        conv("nan", {1'b0, 9'd511, 22'h200000}, 32'h0, 4'b1001, 1);

        conv("min_int", {1'b1, 9'd286, 22'h0}, 32'h80000000, 4'b0000, 1);
        conv("pos_2p31", {1'b0, 9'd286, 22'h0}, 32'h7FFFFFFF, 4'b0100, 1);
        conv("neg_big", {1'b1, 9'd300, 22'h0}, 32'h80000000, 4'b0100, 1);
        conv("k30_ones", {1'b0, 9'd285, 22'h3FFFFF},
             32'h7FFFFF00, 4'b0000, 11);

        // Backpressure: hold DONE while a new word waits on in_valid.
        send(F_M6);
        result("bp", 32'hFFFFFFFA, 4'b0000, 23);
        bus.float_in = F_2P22;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_int", bus.int_out, 32'hFFFFFFFA);
        end
        take();
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        send(F_2P22);
        result("bp_next", 32'h00400000, 4'b0000, 3);
        take();

        // Reset in the middle of a long shift.
        send(F_1P25);
        repeat (5) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_int", bus.int_out, 32'd0);
        check("mid_rst_flags", 32'(bus.flags_out), 32'd0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        conv("post_rst_m6", F_M6, 32'hFFFFFFFA, 4'b0000, 23);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
